// File: rtl/output_requant_packer.sv
// Requantises signed accumulator samples to IO_DATA_WIDTH and packs them into MEM_BW beats.
// The beats stream out through a small FIFO with valid/ready handshaking.
module output_requant_packer #(
    parameter int IO_DATA_WIDTH      = 8,
    parameter int ACCUMULATION_WIDTH = 32,
    parameter int MEM_BW             = 128,
    parameter int OUTPUT_NB_CHANNELS = 64,
    parameter int SHIFT_WIDTH        = 5,
    parameter int FIFO_DEPTH         = 2
) (
    input  logic                          clk,
    input  logic                          arst_in,
    input  logic [SHIFT_WIDTH-1:0]        cfg_shift,
    input  logic                          cfg_relu,
    input  logic                          cfg_load,
    input  logic [ACCUMULATION_WIDTH-1:0] acc_in,
    input  logic                          acc_valid,
    input  logic                          acc_last,
    output logic                          acc_ready,
    output logic [MEM_BW-1:0]             out,
    output logic                          out_valid,
    output logic                          out_last,
    input  logic                          out_ready,
    output logic                          busy,
    output logic [15:0]                   sat_count
);

    localparam int LANES  = MEM_BW / IO_DATA_WIDTH;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CHAN_W = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int AW1    = ACCUMULATION_WIDTH + 1;

    localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [CHAN_W-1:0]     LAST_CHAN = CHAN_W'(OUTPUT_NB_CHANNELS - 1);
    localparam logic [PTR_W-1:0]      LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic signed [AW1-1:0] QMAX      = AW1'((1 << (IO_DATA_WIDTH - 1)) - 1);
    localparam logic signed [AW1-1:0] QMIN      = ~QMAX;

    logic [SHIFT_WIDTH-1:0]   shift_q;
    logic                     relu_q;
    logic [LANE_W-1:0]        lane_q;
    logic [CHAN_W-1:0]        chan_q;
    logic [MEM_BW-1:0]        pack_q;
    logic                     acc_ready_q;

    logic [MEM_BW-1:0]        mem_data [FIFO_DEPTH];
    logic                     mem_last [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         count_q;
    logic [CNT_W-1:0]         count_next;

    logic [AW1-1:0]           half;
    logic signed [AW1-1:0]    s_ext;
    logic signed [AW1-1:0]    s_rnd;
    logic signed [AW1-1:0]    y_shift;
    logic signed [AW1-1:0]    y_relu;
    logic [IO_DATA_WIDTH-1:0] q;
    logic                     sat;

    logic                     accept;
    logic                     beat_done;
    logic                     beat_last;
    logic                     push;
    logic                     pop;
    logic [MEM_BW-1:0]        beat_data;

    // Round-half-up then arithmetic shift, ReLU, saturate
    always_comb begin
        half  = '0;
        s_ext = {acc_in[ACCUMULATION_WIDTH-1], acc_in};
        if (shift_q != '0)
            half = AW1'(1) << (shift_q - SHIFT_WIDTH'(1));
        s_rnd   = s_ext + $signed(half);
        y_shift = s_rnd >>> shift_q;
        y_relu  = y_shift;
        if (relu_q && y_shift[AW1-1])
            y_relu = '0;
        sat = 1'b0;
        q   = y_relu[IO_DATA_WIDTH-1:0];
        if (y_relu > QMAX) begin
            q   = QMAX[IO_DATA_WIDTH-1:0];
            sat = 1'b1;
        end else if (y_relu < QMIN) begin
            q   = QMIN[IO_DATA_WIDTH-1:0];
            sat = 1'b1;
        end
    end

    assign accept    = acc_valid && acc_ready_q;
    assign beat_last = acc_last || (chan_q == LAST_CHAN);
    assign beat_done = beat_last || (lane_q == LAST_LANE);
    assign push      = accept && beat_done;
    assign pop       = out_valid && out_ready;

    // pack_q is cleared on every push, so lanes above the current one are already zero
    always_comb begin
        beat_data = pack_q;
        beat_data[int'(lane_q) * IO_DATA_WIDTH +: IO_DATA_WIDTH] = q;
    end

    always_comb begin
        count_next = count_q;
        if (push && !pop)
            count_next = count_q + CNT_W'(1);
        else if (!push && pop)
            count_next = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            shift_q     <= '0;
            relu_q      <= 1'b0;
            lane_q      <= '0;
            chan_q      <= '0;
            pack_q      <= '0;
            acc_ready_q <= 1'b0;
            sat_count   <= '0;
        end else begin
            acc_ready_q <= (count_next < CNT_W'(FIFO_DEPTH));
            if (cfg_load && !busy) begin
                shift_q <= cfg_shift;
                relu_q  <= cfg_relu;
            end
            if (accept) begin
                if (sat && sat_count != '1)
                    sat_count <= sat_count + 16'd1;
                if (beat_done) begin
                    pack_q <= '0;
                    lane_q <= '0;
                end else begin
                    pack_q <= beat_data;
                    lane_q <= lane_q + LANE_W'(1);
                end
                if (beat_last)
                    chan_q <= '0;
                else
                    chan_q <= chan_q + CHAN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_last[i] <= 1'b0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_next;
            if (push) begin
                mem_data[wr_ptr] <= beat_data;
                mem_last[wr_ptr] <= beat_last;
                wr_ptr           <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
        end
    end

    assign acc_ready = acc_ready_q;
    assign out       = mem_data[rd_ptr];
    assign out_last  = mem_last[rd_ptr];
    assign out_valid = (count_q != '0);
    assign busy      = (lane_q != '0) || (count_q != '0);

endmodule
